gpa_fhdo_seq: RTL and testbench



---
 rtl/gpa_fhdo_pkg.sv | 28 ++
 rtl/gpa_fhdo_seq_if.sv | 20 ++
 rtl/gpa_fhdo_cmd_pack.sv | 19 +
 rtl/gpa_fhdo_seq.sv | 115 +++++++++++
 tb/tb_gpa_fhdo_seq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpa_fhdo_pkg.sv
// Shared types and command-word layout for the GPA-FHDO update sequencer.
package gpa_fhdo_pkg;
  localparam int NUM_CH   = 4;
  localparam int CH_W     = 16;
  localparam int CH_LSB   = 25;
  localparam int SYNC_BIT = 24;
  localparam int ADDR_LSB = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  typedef logic [NUM_CH-1:0][CH_W-1:0] upd_t;

  // {found, index} of the lowest set mask bit at or above 'from'
  function automatic logic [2:0] next_set(input logic [NUM_CH-1:0] mask, input int from);
    logic [2:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (mask[i] && i >= from) r = {1'b1, 2'(i)};
    return r;
  endfunction

  function automatic logic [1:0] hi_set(input logic [NUM_CH-1:0] mask);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (mask[i]) r = 2'(i);
    return r;
  endfunction
endpackage

// File: rtl/gpa_fhdo_seq_if.sv
// Update-side handshake plus SPI-core command port of the sequencer.
interface gpa_fhdo_seq_if;
  logic [63:0] upd_data_i;
  logic        upd_valid_i;
  logic        upd_ready_o;
  logic [31:0] iface_data_o;
  logic        iface_valid_o;
  logic        iface_busy_i;
  logic        done_o;
  logic        err_o;

  modport slave (
    input  upd_data_i, upd_valid_i, iface_busy_i,
    output upd_ready_o, iface_data_o, iface_valid_o, done_o, err_o
  );
  modport master (
    output upd_data_i, upd_valid_i, iface_busy_i,
    input  upd_ready_o, iface_data_o, iface_valid_o, done_o, err_o
  );
endinterface

// File: rtl/gpa_fhdo_cmd_pack.sv
// Packs channel, sync, register address and value into a DAC80504 write word.
module gpa_fhdo_cmd_pack
  import gpa_fhdo_pkg::*;
#(
  parameter logic [3:0] ADDR_BASE = 4'h8
) (
  input  logic [1:0]  ch,
  input  logic        sync,
  input  logic [15:0] value,
  output logic [31:0] word
);
  always_comb begin
    word                 = '0;
    word[CH_LSB +: 2]    = ch;
    word[SYNC_BIT]       = sync;
    word[ADDR_LSB +: 4]  = ADDR_BASE + {2'b00, ch};
    word[15:0]           = value;
  end
endmodule

// File: rtl/gpa_fhdo_seq.sv
// GPA-FHDO update sequencer: one 4-channel update -> up to four paced DAC commands.
// Optional GPA_FHDO_SEQ_CHANGED_ONLY_EN: issue only channels that differ from the last sent value.
module gpa_fhdo_seq
  import gpa_fhdo_pkg::*;
#(
  parameter int         ACK_TIMEOUT   = 64,
  parameter logic [3:0] DAC_ADDR_BASE = 4'h8
) (
  input  logic           clk,
  input  logic           rst,
  gpa_fhdo_seq_if.slave  bus
);
  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  state_t            state, state_n;
  logic [1:0]        ch;
  upd_t              shadow, src;
  logic              live, done, err, load, fin, tmo, accept;
  logic [TW-1:0]     cnt;
  logic [31:0]       data, word;
  logic [NUM_CH-1:0] chg;
  logic [2:0]        nxt;
  logic [1:0]        hi;
  int                from;

  assign bus.upd_ready_o   = live && (state == IDLE);
  assign bus.iface_valid_o = (state == ISSUE);
  assign bus.iface_data_o  = data;
  assign bus.done_o        = done;
  assign bus.err_o         = err;

  assign accept = bus.upd_valid_i && bus.upd_ready_o;
  // In IDLE the channel search runs on the incoming word so ISSUE can follow acceptance directly
  assign src    = (state == IDLE) ? upd_t'(bus.upd_data_i) : shadow;

`ifdef GPA_FHDO_SEQ_CHANGED_ONLY_EN
  upd_t last;

  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_CH; i++) chg[i] = (src[i] != last[i]);
  end

  // A channel counts as sent once its command is loaded for ISSUE
  always_ff @(posedge clk or posedge rst)
    if (rst)       last <= '0;
    else if (load) last[nxt[1:0]] <= src[nxt[1:0]];
`else
  assign chg = '1;
`endif

  always_comb begin
    from = (state == IDLE) ? 0 : int'(ch) + 1;
    nxt  = next_set(chg, from);
    hi   = hi_set(chg);
  end

  gpa_fhdo_cmd_pack #(.ADDR_BASE(DAC_ADDR_BASE)) u_pack (
    .ch    (nxt[1:0]),
    .sync  (nxt[1:0] == hi),
    .value (src[nxt[1:0]]),
    .word  (word)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    fin     = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE:
        if (accept) begin
          if (nxt[2]) begin state_n = ISSUE; load = 1'b1; end
          else        fin = 1'b1;
        end
      ISSUE: state_n = WAIT_ACK;
      WAIT_ACK:
        if (bus.iface_busy_i) state_n = WAIT_DONE;
        else if (cnt == TW'(ACK_TIMEOUT - 1)) begin
          state_n = WAIT_DONE;
          tmo     = 1'b1;
        end
      WAIT_DONE:
        if (!bus.iface_busy_i) begin
          if (nxt[2]) begin state_n = ISSUE; load = 1'b1; end
          else begin state_n = IDLE; fin = 1'b1; end
        end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ch     <= '0;
      shadow <= '0;
      live   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
      data   <= '0;
    end else begin
      live  <= 1'b1;
      state <= state_n;
      done  <= fin;
      if (tmo)    err    <= 1'b1;
      if (accept) shadow <= bus.upd_data_i;
      if (state == ISSUE)         cnt <= '0;
      else if (state == WAIT_ACK) cnt <= cnt + TW'(1);
      if (load) begin
        ch   <= nxt[1:0];
        data <= word;
      end
    end
  end
endmodule

// File: tb/tb_gpa_fhdo_seq.sv
// Self-checking bench for gpa_fhdo_seq with a behavioural busy model and command scoreboard.
module tb_gpa_fhdo_seq;
  localparam int ACK_TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  gpa_fhdo_seq_if bus();

  gpa_fhdo_seq #(.ACK_TIMEOUT(ACK_TIMEOUT), .DAC_ADDR_BASE(4'h8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0, done_bad = 0;
  int busy_len = 40;
  int rem = 0;
  logic [31:0] got[$], exp_q[$];
  int tms[$];
  logic [15:0] mlast[4];

  // Monitor and SPI-core model: busy rises the cycle after a strobe and lasts busy_len cycles
  always @(negedge clk) begin
    cyc++;
    if (bus.iface_valid_o === 1'b1) begin got.push_back(bus.iface_data_o); tms.push_back(cyc); end
    if (bus.done_o === 1'b1) begin done_cnt++; if (bus.upd_ready_o !== 1'b1) done_bad++; end
    if (rst) rem = 0;
    else begin
      if (rem > 0) rem--;
      if (bus.iface_valid_o === 1'b1) rem = busy_len + 1;
    end
    bus.iface_busy_i = (rem > 0) && (rem <= busy_len);
  end

  function automatic logic [63:0] last_vec();
    return {mlast[3], mlast[2], mlast[1], mlast[0]};
  endfunction

  function automatic logic [63:0] mk_diff(input logic [63:0] r);
    logic [63:0] d;
    d = {$urandom, $urandom};
    for (int i = 0; i < 4; i++)
      if (d[16*i +: 16] == r[16*i +: 16]) d[16*i +: 16] = r[16*i +: 16] ^ 16'h0001;
    return d;
  endfunction

  // Expected DAC commands for one update, straight from the command format rules
  task automatic model_push(input logic [63:0] d);
    bit chg[4];
    int hi;
    logic [15:0] v;
    hi = -1;
    for (int i = 0; i < 4; i++) begin
      v = d[16*i +: 16];
`ifdef GPA_FHDO_SEQ_CHANGED_ONLY_EN
      chg[i] = (v != mlast[i]);
`else
      chg[i] = 1'b1;
`endif
      if (chg[i]) hi = i;
    end
    for (int i = 0; i < 4; i++)
      if (chg[i]) begin
        v = d[16*i +: 16];
        exp_q.push_back((32'(i) << 25) | ((i == hi) ? 32'h0100_0000 : 32'h0) |
                        (32'((8 + i) % 16) << 16) | 32'(v));
        mlast[i] = v;
      end
  endtask

  task automatic clear_q();
    got.delete(); exp_q.delete(); tms.delete();
  endtask

  task automatic drive(input logic [63:0] d);
    for (int k = 0; k < 3000 && bus.upd_ready_o !== 1'b1; k++) begin @(negedge clk); #1; end
    n_cmp++;
    if (bus.upd_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL drive_ready: got %b want 1", bus.upd_ready_o);
    end
    bus.upd_data_i  = d;
    bus.upd_valid_i = 1'b1;
    @(negedge clk); #1;
    bus.upd_valid_i = 1'b0;
    model_push(d);
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 6000 && done_cnt < target; k++) begin @(negedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp += 5;
    if (bus.upd_ready_o !== 1'b0)  begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus.upd_ready_o); end
    if (bus.iface_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.iface_valid_o); end
    if (bus.iface_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", bus.iface_data_o); end
    if (bus.done_o !== 1'b0)        begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.done_o); end
    if (bus.err_o !== 1'b0)         begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.err_o); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mlast[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.upd_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", bus.upd_ready_o); end
  endtask

  task automatic test_directed();
    logic [31:0] want[4];
    int base;
    want = '{32'h0008_0001, 32'h0209_0002, 32'h040A_0003, 32'h070B_0004};
    clear_q(); busy_len = 40; base = done_cnt;
    drive(64'h0004_0003_0002_0001);
    n_cmp++;
    if (bus.upd_ready_o !== 1'b0) begin n_bad++; $display("FAIL dir_ready_drop: got %b want 0", bus.upd_ready_o); end
    wait_done(base + 1);
    n_cmp += 3;
    if (done_cnt != base + 1) begin n_bad++; $display("FAIL dir_done: got %0d want %0d", done_cnt - base, 1); end
    if (done_bad != 0)        begin n_bad++; $display("FAIL dir_done_ready: got %0d want 0", done_bad); end
    if (got.size() != 4)      begin n_bad++; $display("FAIL dir_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== want[i]) begin n_bad++; $display("FAIL dir_word%0d: got %h want %h", i, got[i], want[i]); end
    end
  endtask

`ifdef GPA_FHDO_SEQ_CHANGED_ONLY_EN
  task automatic test_changed_only();
    int base;
    clear_q(); busy_len = 10; base = done_cnt;
    drive(64'h0004_0003_0009_0001);
    wait_done(base + 1);
    n_cmp += 2;
    if (got.size() != 1) begin n_bad++; $display("FAIL chg_count: got %0d want 1", got.size()); end
    else if (got[0] !== 32'h0309_0009) begin n_bad++; $display("FAIL chg_word: got %h want 03090009", got[0]); end
    if (done_cnt != base + 1) begin n_bad++; $display("FAIL chg_done: got %0d want 1", done_cnt - base); end
    clear_q(); base = done_cnt;
    drive(64'h0004_0003_0009_0001);
    n_cmp += 2;
    if (done_cnt != base + 1) begin n_bad++; $display("FAIL nochg_done: got %0d want 1", done_cnt - base); end
    repeat (5) @(negedge clk);
    #1;
    if (got.size() != 0) begin n_bad++; $display("FAIL nochg_count: got %0d want 0", got.size()); end
  endtask
`endif

  task automatic test_random();
    int base;
    clear_q(); base = done_cnt;
    for (int r = 0; r < 5; r++) begin
      busy_len = $urandom_range(1, 8);
      drive(mk_diff(last_vec()));
      wait_done(base + r + 1);
    end
    n_cmp += 3;
    if (done_cnt != base + 5)        begin n_bad++; $display("FAIL rnd_done: got %0d want 5", done_cnt - base); end
    if (got.size() != exp_q.size())  begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", got.size(), exp_q.size()); end
    if (bus.err_o !== 1'b0)          begin n_bad++; $display("FAIL rnd_err: got %b want 0", bus.err_o); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd_word%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_hold_off();
    int base, viol;
    logic [63:0] a, b;
    clear_q(); busy_len = 20; base = done_cnt; viol = 0;
    a = mk_diff(last_vec());
    b = mk_diff(a);
    drive(a);
    bus.upd_data_i  = b;
    bus.upd_valid_i = 1'b1;
    for (int k = 0; k < 3000 && done_cnt == base; k++) begin
      if (bus.upd_ready_o !== 1'b0) viol++;
      @(negedge clk); #1;
    end
    model_push(b);
    @(negedge clk); #1;
    bus.upd_valid_i = 1'b0;
    n_cmp += 2;
    if (viol != 0)                 begin n_bad++; $display("FAIL hold_ready_low: got %0d high cycles want 0", viol); end
    if (bus.upd_ready_o !== 1'b0)  begin n_bad++; $display("FAIL hold_accept_b: got %b want 0", bus.upd_ready_o); end
    wait_done(base + 2);
    n_cmp += 2;
    if (done_cnt != base + 2)       begin n_bad++; $display("FAIL hold_done: got %0d want 2", done_cnt - base); end
    if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL hold_count: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL hold_word%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int base, min_gap;
    logic [63:0] a;
    clear_q(); busy_len = 1; base = done_cnt; min_gap = 1000;
    a = mk_diff(last_vec());
    drive(a);
    drive(mk_diff(a));
    wait_done(base + 2);
    for (int i = 1; i < tms.size(); i++)
      if (tms[i] - tms[i-1] < min_gap) min_gap = tms[i] - tms[i-1];
    n_cmp += 3;
    if (got.size() != 8)      begin n_bad++; $display("FAIL b2b_count: got %0d want 8", got.size()); end
    if (min_gap < 3)          begin n_bad++; $display("FAIL b2b_gap: got %0d want >=3", min_gap); end
    if (done_cnt != base + 2) begin n_bad++; $display("FAIL b2b_done: got %0d want 2", done_cnt - base); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_word%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int base, v;
    clear_q(); busy_len = 0; base = done_cnt;
    drive(mk_diff(last_vec()));
    for (int k = 0; k < 100 && tms.size() == 0; k++) begin @(negedge clk); #1; end
    n_cmp++;
    if (tms.size() == 0) begin
      n_bad++; $display("FAIL tmo_first_strobe: got none want 1");
    end else begin
      v = tms[0];
      while (cyc < v + ACK_TIMEOUT - 1) begin @(negedge clk); #1; end
      n_cmp++;
      if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL tmo_err_early: got %b want 0", bus.err_o); end
      while (cyc < v + ACK_TIMEOUT + 1) begin @(negedge clk); #1; end
      n_cmp++;
      if (bus.err_o !== 1'b1) begin n_bad++; $display("FAIL tmo_err_set: got %b want 1", bus.err_o); end
    end
    wait_done(base + 1);
    n_cmp += 3;
    if (done_cnt != base + 1)       begin n_bad++; $display("FAIL tmo_done: got %0d want 1", done_cnt - base); end
    if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL tmo_count: got %0d want %0d", got.size(), exp_q.size()); end
    if (bus.err_o !== 1'b1)         begin n_bad++; $display("FAIL tmo_err_sticky: got %b want 1", bus.err_o); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL tmo_word%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int base, n;
    clear_q(); busy_len = 40; base = done_cnt;
    drive(mk_diff(last_vec()));
    for (int k = 0; k < 500 && got.size() < 2; k++) begin @(negedge clk); #1; end
    n_cmp++;
    if (got.size() < 2) begin n_bad++; $display("FAIL mid_ch1_strobe: got %0d want 2", got.size()); end
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp += 5;
    if (bus.upd_ready_o !== 1'b0)   begin n_bad++; $display("FAIL mid_ready: got %b want 0", bus.upd_ready_o); end
    if (bus.iface_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", bus.iface_valid_o); end
    if (bus.iface_data_o !== 32'h0) begin n_bad++; $display("FAIL mid_data: got %h want 0", bus.iface_data_o); end
    if (bus.done_o !== 1'b0)        begin n_bad++; $display("FAIL mid_done: got %b want 0", bus.done_o); end
    if (bus.err_o !== 1'b0)         begin n_bad++; $display("FAIL mid_err: got %b want 0", bus.err_o); end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mlast[i] = '0;
    n = got.size();
    repeat (150) @(negedge clk);
    #1;
    n_cmp += 2;
    if (got.size() != n)    begin n_bad++; $display("FAIL mid_no_strobe: got %0d want 0", got.size() - n); end
    if (done_cnt != base)   begin n_bad++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - base); end
  endtask

  initial begin
    bus.upd_data_i  = '0;
    bus.upd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) mlast[i] = '0;
    test_reset();
    test_directed();
`ifdef GPA_FHDO_SEQ_CHANGED_ONLY_EN
    test_changed_only();
`endif
    test_random();
    test_hold_off();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
